rx_frame_parser: RTL and testbench
==================================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 The block SHALL have parameter SOF_BYTE, default 8'hA5, the start-of-frame marker.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, the inter-byte timeout in clocks; it is used only when RX_FRAME_TIMEOUT_EN is defined.
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port i_rst, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port i_rx_data, input, 8 bits, the byte from the UART receiver.
REQ-006 The block SHALL have port i_rx_valid, input, 1 bit, a one-cycle strobe qualifying i_rx_data; strobes may arrive back-to-back.
REQ-007 The block SHALL have port o_data, output, 8 bits, the payload byte to the task stage.
REQ-008 The block SHALL have port o_valid, output, 1 bit, a one-cycle strobe qualifying o_data.
REQ-009 The block SHALL have port o_first, output, 1 bit, asserted with the first payload byte of a frame.
REQ-010 The block SHALL have port o_last, output, 1 bit, asserted with the final payload byte of a frame.
REQ-011 The block SHALL have port o_err, output, 1 bit, a one-cycle error strobe.
REQ-012 The block SHALL have port o_err_code, output, 2 bits, the error cause qualified by o_err: 01 = zero length, 10 = checksum mismatch, 11 = timeout.

Function
REQ-013 Frame format SHALL be: SOF_BYTE, LEN (1..255), LEN payload bytes, CHK; CHK = XOR of all payload bytes.
REQ-014 The FSM SHALL have four states: IDLE, LEN, PAYLOAD, CHK; state advances only on cycles where i_rx_valid=1.
REQ-015 In IDLE, a byte equal to SOF_BYTE SHALL move the FSM to LEN; any other byte SHALL be discarded silently.
REQ-016 In LEN, a byte of 0 SHALL pulse o_err with o_err_code=01 on the next cycle and return the FSM to IDLE; a nonzero byte SHALL load the down-counter and clear the XOR accumulator, then move the FSM to PAYLOAD.
REQ-017 In PAYLOAD, each byte SHALL appear on o_data with o_valid=1 exactly one cycle after its i_rx_valid strobe, and the byte SHALL be XORed into the accumulator.
REQ-018 o_first SHALL be asserted only with payload byte 1, and o_last only with payload byte LEN; when LEN=1, both SHALL be asserted on the same beat.
REQ-019 After payload byte LEN, the FSM SHALL move to CHK.
REQ-020 In CHK, if the received byte differs from the accumulator, o_err SHALL pulse with o_err_code=10 one cycle later; if it matches, no strobe SHALL occur; in both cases the FSM SHALL return to IDLE.
REQ-021 A SOF_BYTE value received inside LEN, PAYLOAD or CHK SHALL be treated as data, not as resync.
REQ-022 All outputs SHALL be registered; o_data SHALL hold its last value while o_valid=0; o_first, o_last and o_valid SHALL be 0 outside payload beats.
REQ-023 The block SHALL have no backpressure; the downstream stage SHALL accept every o_valid beat.

Reset
REQ-024 When i_rst=1 at a rising edge of i_clk, the next state SHALL be: FSM IDLE, counters and accumulator 0, and o_data, o_valid, o_first, o_last, o_err and o_err_code all 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no o_last and no o_err; bytes that follow SHALL be ignored until a new SOF_BYTE arrives.

Configuration
REQ-026 When macro RX_FRAME_TIMEOUT_EN is defined, an idle counter SHALL clear on every i_rx_valid, and after TIMEOUT_CYCLES consecutive cycles without i_rx_valid while in LEN, PAYLOAD or CHK it SHALL pulse o_err with o_err_code=11 and force the FSM to IDLE, with no o_last emitted.
REQ-027 If an i_rx_valid strobe arrives in the cycle the timeout would expire, the byte SHALL win and no timeout SHALL occur.
REQ-028 When RX_FRAME_TIMEOUT_EN is undefined, the block SHALL contain no counter, SHALL wait indefinitely in every state, SHALL ignore TIMEOUT_CYCLES, and SHALL never produce o_err_code=11.

Verification
REQ-029 Stimulus A5 03 11 22 33 00 -> three o_valid beats 11/22/33; o_first on 11; o_last on 33; no o_err.
REQ-030 Stimulus A5 01 7E 7E -> one beat 7E with o_first=o_last=1; no o_err.
REQ-031 Stimulus A5 02 01 02 FF -> beats 01, 02 (o_last on 02); o_err=1 with o_err_code=10 one cycle after the FF strobe.
REQ-032 Stimulus 00 A5 00, then A5 01 55 55 -> leading 00 ignored; o_err with o_err_code=01; following frame yields beat 55 with o_first=o_last=1.
REQ-033 With RX_FRAME_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, stimulus A5 02 10 followed by silence -> beat 10 with o_first=1; o_err with o_err_code=11 after 16 idle cycles; no o_last; the next frame parses correctly.
REQ-034 Stimulus: frame A5 04, two payload bytes, i_rst=1 for one cycle, then the remaining bytes -> all outputs 0 after the reset edge; no further beats until the next A5-framed packet.

Source files
------------

// File: rtl/rx_frame_parser_if.sv
// Byte stream from the UART receiver in, parsed payload beats and error strobes out.
// The parser takes the slave modport; whoever feeds it takes the master modport.
interface rx_frame_parser_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_first;
    logic       o_last;
    logic       o_err;
    logic [1:0] o_err_code;

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_data, o_valid, o_first, o_last, o_err, o_err_code
    );

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_data, o_valid, o_first, o_last, o_err, o_err_code
    );
endinterface

// File: rtl/rx_frame_parser.sv
// Frame parser: SOF, LEN, LEN payload bytes, XOR checksum; emits payload beats and error strobes.
// Define RX_FRAME_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES idle clocks (error code 11).
module rx_frame_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input logic              i_clk,
    input logic              i_rst,
    rx_frame_parser_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] acc_q, acc_d;
    logic       first_pend_q, first_pend_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       first_q, first_d;
    logic       last_q, last_d;
    logic       err_q, err_d;
    logic [1:0] code_q, code_d;
    logic       timeout;

`ifdef RX_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q;

    // Counts consecutive silent cycles while a frame is open; any byte restarts it.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_rx_valid || state_q == IDLE) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + 1'b1;
        end
    end

    assign timeout = !bus.i_rx_valid && (state_q != IDLE) &&
                     (idle_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            first_pend_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            first_pend_q <= first_pend_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            err_q        <= err_d;
            code_q       <= code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        first_pend_d = first_pend_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        first_d      = 1'b0;
        last_d       = 1'b0;
        err_d        = 1'b0;
        code_d       = 2'b00;

        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = 2'b11;
        end else if (bus.i_rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (bus.i_rx_data == SOF_BYTE) begin
                        state_d = LEN;
                    end
                end
                LEN: begin
                    if (bus.i_rx_data == 8'd0) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = IDLE;
                    end else begin
                        cnt_d        = bus.i_rx_data;
                        acc_d        = 8'd0;
                        first_pend_d = 1'b1;
                        state_d      = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // cnt_q holds the bytes still due, so 1 marks the final beat.
                    data_d       = bus.i_rx_data;
                    valid_d      = 1'b1;
                    first_d      = first_pend_q;
                    first_pend_d = 1'b0;
                    acc_d        = acc_q ^ bus.i_rx_data;
                    cnt_d        = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        last_d  = 1'b1;
                        state_d = CHK;
                    end
                end
                CHK: begin
                    if (bus.i_rx_data != acc_q) begin
                        err_d  = 1'b1;
                        code_d = 2'b10;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_first    = first_q;
    assign bus.o_last     = last_q;
    assign bus.o_err      = err_q;
    assign bus.o_err_code = code_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: one byte (or idle) per clock, outputs checked #1 after each edge.
// The timeout section is active when RX_FRAME_TIMEOUT_EN is defined for both RTL and bench.
module tb_rx_frame_parser;

    logic clk;
    logic rst;
    int   test_count;
    int   fail_count;

    rx_frame_parser_if bus ();

    rx_frame_parser #(
        .SOF_BYTE      (8'hA5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
        rst            = r;
        bus.i_rx_valid = v;
        bus.i_rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Packed as {valid, first, last, err, code[1:0], data[7:0]}.
    task automatic checkOutput(input string tag, input logic v, input logic f, input logic l,
                               input logic e, input logic [1:0] c, input logic [7:0] d);
        logic [13:0] observed;
        logic [13:0] expected;
        observed = {bus.o_valid, bus.o_first, bus.o_last, bus.o_err, bus.o_err_code, bus.o_data};
        expected = {v, f, l, e, c, d};
        test_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed v/f/l/e/code/data=%b/%b/%b/%b/%b/%h expected %b/%b/%b/%b/%b/%h",
                   tag, observed[13], observed[12], observed[11], observed[10], observed[9:8],
                   observed[7:0], v, f, l, e, c, d);
        end
    endtask

    initial begin
        test_count     = 0;
        fail_count     = 0;
        rst            = 1'b1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;

        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("reset", 0, 0, 0, 0, 2'b00, 8'h00);

        // Good three-byte frame, back-to-back strobes
        applyStimulus(0, 1, 8'hA5); checkOutput("a_sof", 0, 0, 0, 0, 2'b00, 8'h00);
        applyStimulus(0, 1, 8'h03); checkOutput("a_len", 0, 0, 0, 0, 2'b00, 8'h00);
        applyStimulus(0, 1, 8'h11); checkOutput("a_b1", 1, 1, 0, 0, 2'b00, 8'h11);
        applyStimulus(0, 1, 8'h22); checkOutput("a_b2", 1, 0, 0, 0, 2'b00, 8'h22);
        applyStimulus(0, 1, 8'h33); checkOutput("a_b3", 1, 0, 1, 0, 2'b00, 8'h33);
        applyStimulus(0, 1, 8'h00); checkOutput("a_chk", 0, 0, 0, 0, 2'b00, 8'h33);

        // LEN=1: first and last on the same beat
        applyStimulus(0, 1, 8'hA5); checkOutput("b_sof", 0, 0, 0, 0, 2'b00, 8'h33);
        applyStimulus(0, 1, 8'h01); checkOutput("b_len", 0, 0, 0, 0, 2'b00, 8'h33);
        applyStimulus(0, 1, 8'h7E); checkOutput("b_b1", 1, 1, 1, 0, 2'b00, 8'h7E);
        applyStimulus(0, 1, 8'h7E); checkOutput("b_chk", 0, 0, 0, 0, 2'b00, 8'h7E);

        // Checksum mismatch: 01^02 = 03, FF received
        applyStimulus(0, 1, 8'hA5); checkOutput("c_sof", 0, 0, 0, 0, 2'b00, 8'h7E);
        applyStimulus(0, 1, 8'h02); checkOutput("c_len", 0, 0, 0, 0, 2'b00, 8'h7E);
        applyStimulus(0, 1, 8'h01); checkOutput("c_b1", 1, 1, 0, 0, 2'b00, 8'h01);
        applyStimulus(0, 1, 8'h02); checkOutput("c_b2", 1, 0, 1, 0, 2'b00, 8'h02);
        applyStimulus(0, 1, 8'hFF); checkOutput("c_chkerr", 0, 0, 0, 1, 2'b10, 8'h02);
        applyStimulus(0, 0, 8'h00); checkOutput("c_errpulse", 0, 0, 0, 0, 2'b00, 8'h02);

        // Leading junk ignored, zero length error, then a good frame
        applyStimulus(0, 1, 8'h00); checkOutput("d_junk", 0, 0, 0, 0, 2'b00, 8'h02);
        applyStimulus(0, 1, 8'hA5); checkOutput("d_sof", 0, 0, 0, 0, 2'b00, 8'h02);
        applyStimulus(0, 1, 8'h00); checkOutput("d_zerolen", 0, 0, 0, 1, 2'b01, 8'h02);
        applyStimulus(0, 1, 8'hA5); checkOutput("d_sof2", 0, 0, 0, 0, 2'b00, 8'h02);
        applyStimulus(0, 1, 8'h01); checkOutput("d_len2", 0, 0, 0, 0, 2'b00, 8'h02);
        applyStimulus(0, 1, 8'h55); checkOutput("d_b1", 1, 1, 1, 0, 2'b00, 8'h55);
        applyStimulus(0, 1, 8'h55); checkOutput("d_chk", 0, 0, 0, 0, 2'b00, 8'h55);

        // Gaps between strobes and SOF value as payload: A5^01 = A4
        applyStimulus(0, 1, 8'hA5); checkOutput("e_sof", 0, 0, 0, 0, 2'b00, 8'h55);
        applyStimulus(0, 1, 8'h02); checkOutput("e_len", 0, 0, 0, 0, 2'b00, 8'h55);
        applyStimulus(0, 0, 8'hA5); checkOutput("e_gap1", 0, 0, 0, 0, 2'b00, 8'h55);
        applyStimulus(0, 1, 8'hA5); checkOutput("e_b1sof", 1, 1, 0, 0, 2'b00, 8'hA5);
        applyStimulus(0, 0, 8'h00); checkOutput("e_gap2", 0, 0, 0, 0, 2'b00, 8'hA5);
        applyStimulus(0, 1, 8'h01); checkOutput("e_b2", 1, 0, 1, 0, 2'b00, 8'h01);
        applyStimulus(0, 1, 8'hA4); checkOutput("e_chk", 0, 0, 0, 0, 2'b00, 8'h01);

        // Reset mid-frame abandons it; trailing bytes ignored until a new SOF
        applyStimulus(0, 1, 8'hA5); checkOutput("f_sof", 0, 0, 0, 0, 2'b00, 8'h01);
        applyStimulus(0, 1, 8'h04); checkOutput("f_len", 0, 0, 0, 0, 2'b00, 8'h01);
        applyStimulus(0, 1, 8'h10); checkOutput("f_b1", 1, 1, 0, 0, 2'b00, 8'h10);
        applyStimulus(0, 1, 8'h20); checkOutput("f_b2", 1, 0, 0, 0, 2'b00, 8'h20);
        applyStimulus(1, 1, 8'h30); checkOutput("f_rst", 0, 0, 0, 0, 2'b00, 8'h00);
        applyStimulus(0, 1, 8'h40); checkOutput("f_drop1", 0, 0, 0, 0, 2'b00, 8'h00);
        applyStimulus(0, 1, 8'h40); checkOutput("f_drop2", 0, 0, 0, 0, 2'b00, 8'h00);
        applyStimulus(0, 1, 8'hA5); checkOutput("f_sof2", 0, 0, 0, 0, 2'b00, 8'h00);
        applyStimulus(0, 1, 8'h01); checkOutput("f_len2", 0, 0, 0, 0, 2'b00, 8'h00);
        applyStimulus(0, 1, 8'h99); checkOutput("f_b1new", 1, 1, 1, 0, 2'b00, 8'h99);
        applyStimulus(0, 1, 8'h99); checkOutput("f_chk", 0, 0, 0, 0, 2'b00, 8'h99);

`ifdef RX_FRAME_TIMEOUT_EN
        // Silence mid-frame: error code 11 on the 16th idle cycle, no last
        applyStimulus(0, 1, 8'hA5); checkOutput("g_sof", 0, 0, 0, 0, 2'b00, 8'h99);
        applyStimulus(0, 1, 8'h02); checkOutput("g_len", 0, 0, 0, 0, 2'b00, 8'h99);
        applyStimulus(0, 1, 8'h10); checkOutput("g_b1", 1, 1, 0, 0, 2'b00, 8'h10);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(0, 0, 8'h00);
            checkOutput("g_idle", 0, 0, 0, 0, 2'b00, 8'h10);
        end
        applyStimulus(0, 0, 8'h00); checkOutput("g_timeout", 0, 0, 0, 1, 2'b11, 8'h10);
        applyStimulus(0, 0, 8'h00); checkOutput("g_after", 0, 0, 0, 0, 2'b00, 8'h10);
        applyStimulus(0, 1, 8'hA5); checkOutput("g_sof2", 0, 0, 0, 0, 2'b00, 8'h10);
        applyStimulus(0, 1, 8'h01); checkOutput("g_len2", 0, 0, 0, 0, 2'b00, 8'h10);
        applyStimulus(0, 1, 8'h66); checkOutput("g_b1new", 1, 1, 1, 0, 2'b00, 8'h66);
        applyStimulus(0, 1, 8'h66); checkOutput("g_chk", 0, 0, 0, 0, 2'b00, 8'h66);

        // A byte landing on the expiry cycle wins: 12^34 = 26
        applyStimulus(0, 1, 8'hA5); checkOutput("h_sof", 0, 0, 0, 0, 2'b00, 8'h66);
        applyStimulus(0, 1, 8'h02); checkOutput("h_len", 0, 0, 0, 0, 2'b00, 8'h66);
        applyStimulus(0, 1, 8'h12); checkOutput("h_b1", 1, 1, 0, 0, 2'b00, 8'h12);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(0, 0, 8'h00);
            checkOutput("h_idle", 0, 0, 0, 0, 2'b00, 8'h12);
        end
        applyStimulus(0, 1, 8'h34); checkOutput("h_bytewins", 1, 0, 1, 0, 2'b00, 8'h34);
        applyStimulus(0, 1, 8'h26); checkOutput("h_chk", 0, 0, 0, 0, 2'b00, 8'h34);
`else
        // Without the timeout an open frame waits indefinitely: 10^20 = 30
        applyStimulus(0, 1, 8'hA5); checkOutput("g_sof", 0, 0, 0, 0, 2'b00, 8'h99);
        applyStimulus(0, 1, 8'h02); checkOutput("g_len", 0, 0, 0, 0, 2'b00, 8'h99);
        applyStimulus(0, 1, 8'h10); checkOutput("g_b1", 1, 1, 0, 0, 2'b00, 8'h10);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 0, 8'h00);
            checkOutput("g_wait", 0, 0, 0, 0, 2'b00, 8'h10);
        end
        applyStimulus(0, 1, 8'h20); checkOutput("g_b2", 1, 0, 1, 0, 2'b00, 8'h20);
        applyStimulus(0, 1, 8'h30); checkOutput("g_chk", 0, 0, 0, 0, 2'b00, 8'h20);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
